// File: rtl/matmul_pkg.sv
// Shared types and helpers for the matrix-multiply address sequencer.
// Default widths and the row-stride product used at sequence start.
package matmul_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int DIM_W_DEF  = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_FIN
  } state_t;

  // n is always an elaboration constant, so this folds to shift-adds
  function automatic int unsigned row_stride(
    input int unsigned n,
    input int unsigned dim
  );
    return n * dim;
  endfunction

endpackage

// File: rtl/mm_loop_counter.sv
// Wrapping loop counter: steps by STEP, reloads INIT on clear or wrap.
// wrap is high when the next step would reach or pass limit.
module mm_loop_counter #(
  parameter int W    = 4,
  parameter int STEP = 1,
  parameter int INIT = 0
) (
  input  logic         clock,
  input  logic         rst_n,
  input  logic         clear,
  input  logic         inc,
  input  logic [W-1:0] limit,
  output logic [W-1:0] count,
  output logic         wrap
);

  localparam logic [W:0]   STEP_V = (W+1)'(STEP);
  localparam logic [W-1:0] INIT_V = W'(INIT);

  logic [W:0] nxt;

  assign nxt  = {1'b0, count} + STEP_V;
  assign wrap = nxt >= {1'b0, limit};

  always_ff @(posedge clock) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= INIT_V;
    end else if (inc) begin
      count <= wrap ? INIT_V : nxt[W-1:0];
    end
  end

endmodule

// File: rtl/matmul_addr_seq.sv
// Per-core A/B/D address sequencer for the i/j/k matmul loop nest.
// Rows are interleaved across cores; addresses advance incrementally.
module matmul_addr_seq
  import matmul_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int DIM_W     = DIM_W_DEF,
  parameter int NUM_CORES = 4,
  parameter int CORE_ID   = 0
) (
  input  logic              clock,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DIM_W-1:0]  dim_i,
  input  logic [DIM_W-1:0]  dim_k,
  input  logic [DIM_W-1:0]  dim_j,
  input  logic [ADDR_W-1:0] base_a,
  input  logic [ADDR_W-1:0] base_b,
  input  logic [ADDR_W-1:0] base_d,
  input  logic              step,
  output logic [ADDR_W-1:0] addr_a,
  output logic [ADDR_W-1:0] addr_b,
  output logic [ADDR_W-1:0] addr_d,
  output logic              last_k,
  output logic              valid,
  output logic              busy,
  output logic              done
);

  state_t state;

  logic [DIM_W-1:0]  di_r;
  logic [DIM_W-1:0]  dk_r;
  logic [DIM_W-1:0]  dj_r;
  logic [ADDR_W-1:0] base_b_r;
  logic [ADDR_W-1:0] row_a;
  logic [ADDR_W-1:0] a_skip;
  logic [ADDR_W-1:0] d_skip;

  logic [DIM_W-1:0] k_cnt;
  logic [DIM_W-1:0] j_cnt;
  logic [DIM_W:0]   i_cnt_unused;
  logic k_wrap;
  logic j_wrap;
  logic i_wrap;

  logic accept;
  logic adv;
  logic empty;

  assign accept = (state == ST_IDLE) && start;
  assign adv    = (state == ST_RUN) && step;

  assign empty = ((DIM_W+1)'(CORE_ID) >= {1'b0, dim_i})
              || (dim_i == '0)
              || (dim_k == '0)
              || (dim_j == '0);

  assign last_k = valid && (k_cnt == dk_r - 1'b1);

  mm_loop_counter #(
    .W(DIM_W), .STEP(1), .INIT(0)
  ) u_k (
    .clock(clock),
    .rst_n(rst_n),
    .clear(accept),
    .inc(adv),
    .limit(dk_r),
    .count(k_cnt),
    .wrap(k_wrap)
  );

  mm_loop_counter #(
    .W(DIM_W), .STEP(1), .INIT(0)
  ) u_j (
    .clock(clock),
    .rst_n(rst_n),
    .clear(accept),
    .inc(adv && k_wrap),
    .limit(dj_r),
    .count(j_cnt),
    .wrap(j_wrap)
  );

  mm_loop_counter #(
    .W(DIM_W+1), .STEP(NUM_CORES), .INIT(CORE_ID)
  ) u_i (
    .clock(clock),
    .rst_n(rst_n),
    .clear(accept),
    .inc(adv && k_wrap && j_wrap),
    .limit({1'b0, di_r}),
    .count(i_cnt_unused),
    .wrap(i_wrap)
  );

  always_ff @(posedge clock) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      valid    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      addr_a   <= '0;
      addr_b   <= '0;
      addr_d   <= '0;
      row_a    <= '0;
      base_b_r <= '0;
      a_skip   <= '0;
      d_skip   <= '0;
      di_r     <= '0;
      dk_r     <= '0;
      dj_r     <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            di_r     <= dim_i;
            dk_r     <= dim_k;
            dj_r     <= dim_j;
            base_b_r <= base_b;
            addr_a   <= base_a
              + ADDR_W'(row_stride(CORE_ID, 32'(dim_k)));
            row_a    <= base_a
              + ADDR_W'(row_stride(CORE_ID, 32'(dim_k)));
            addr_b   <= base_b;
            addr_d   <= base_d
              + ADDR_W'(row_stride(CORE_ID, 32'(dim_j)));
            a_skip   <= ADDR_W'(row_stride(NUM_CORES, 32'(dim_k)));
            // D jumps over the rows owned by the other cores
            d_skip   <= ADDR_W'(row_stride(NUM_CORES - 1, 32'(dim_j)))
              + 1'b1;
            busy     <= 1'b1;
            if (empty) begin
              state <= ST_FIN;
              done  <= 1'b1;
            end else begin
              state <= ST_RUN;
              valid <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (step) begin
            if (!k_wrap) begin
              addr_a <= addr_a + 1'b1;
              addr_b <= addr_b + ADDR_W'(dj_r);
            end else if (!j_wrap) begin
              addr_a <= row_a;
              addr_b <= base_b_r + ADDR_W'(j_cnt) + 1'b1;
              addr_d <= addr_d + 1'b1;
            end else if (!i_wrap) begin
              row_a  <= row_a + a_skip;
              addr_a <= row_a + a_skip;
              addr_b <= base_b_r;
              addr_d <= addr_d + d_skip;
            end else begin
              state <= ST_FIN;
              valid <= 1'b0;
              done  <= 1'b1;
            end
          end
        end
        ST_FIN: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
        default: begin
          state <= ST_IDLE;
          valid <= 1'b0;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_matmul_addr_seq.sv
// Bench for matmul_addr_seq: three core configs against a loop-nest model.
// Directed vectors pin the model with hand-computed address tuples.
module tb_matmul_addr_seq;

  localparam int NC[3]  = '{1, 4, 4};
  localparam int CID[3] = '{0, 1, 2};

  logic       clock = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       step  = 1'b0;
  logic [3:0] dim_i = '0;
  logic [3:0] dim_k = '0;
  logic [3:0] dim_j = '0;
  logic [7:0] base_a = '0;
  logic [7:0] base_b = '0;
  logic [7:0] base_d = '0;

  logic [7:0] a[3];
  logic [7:0] b[3];
  logic [7:0] d[3];
  logic       lk[3];
  logic       vl[3];
  logic       bz[3];
  logic       dn[3];

  int n_chk  = 0;
  int n_fail = 0;
  bit cmp_en = 1'b0;

  always #5 clock = ~clock;

  matmul_addr_seq #(
    .ADDR_W(8), .DIM_W(4), .NUM_CORES(1), .CORE_ID(0)
  ) u0 (
    .clock(clock), .rst_n(rst_n), .start(start),
    .dim_i(dim_i), .dim_k(dim_k), .dim_j(dim_j),
    .base_a(base_a), .base_b(base_b), .base_d(base_d),
    .step(step), .addr_a(a[0]), .addr_b(b[0]), .addr_d(d[0]),
    .last_k(lk[0]), .valid(vl[0]), .busy(bz[0]), .done(dn[0])
  );

  matmul_addr_seq #(
    .ADDR_W(8), .DIM_W(4), .NUM_CORES(4), .CORE_ID(1)
  ) u1 (
    .clock(clock), .rst_n(rst_n), .start(start),
    .dim_i(dim_i), .dim_k(dim_k), .dim_j(dim_j),
    .base_a(base_a), .base_b(base_b), .base_d(base_d),
    .step(step), .addr_a(a[1]), .addr_b(b[1]), .addr_d(d[1]),
    .last_k(lk[1]), .valid(vl[1]), .busy(bz[1]), .done(dn[1])
  );

  matmul_addr_seq #(
    .ADDR_W(8), .DIM_W(4), .NUM_CORES(4), .CORE_ID(2)
  ) u2 (
    .clock(clock), .rst_n(rst_n), .start(start),
    .dim_i(dim_i), .dim_k(dim_k), .dim_j(dim_j),
    .base_a(base_a), .base_b(base_b), .base_d(base_d),
    .step(step), .addr_a(a[2]), .addr_b(b[2]), .addr_d(d[2]),
    .last_k(lk[2]), .valid(vl[2]), .busy(bz[2]), .done(dn[2])
  );

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Loop-nest model: 0 idle, 1 running, 2 finishing
  int m_st[3] = '{0, 0, 0};
  int mi[3];
  int mj[3];
  int mk[3];
  int mdi[3];
  int mdk[3];
  int mdj[3];
  int mba[3];
  int mbb[3];
  int mbd[3];

  always @(posedge clock) begin
    for (int n = 0; n < 3; n++) begin
      if (!rst_n) begin
        m_st[n] <= 0;
      end else if (m_st[n] == 0) begin
        if (start) begin
          mdi[n] <= int'(dim_i);
          mdk[n] <= int'(dim_k);
          mdj[n] <= int'(dim_j);
          mba[n] <= int'(base_a);
          mbb[n] <= int'(base_b);
          mbd[n] <= int'(base_d);
          mi[n]  <= CID[n];
          mj[n]  <= 0;
          mk[n]  <= 0;
          if (CID[n] >= int'(dim_i) || dim_k == 0 || dim_j == 0)
            m_st[n] <= 2;
          else
            m_st[n] <= 1;
        end
      end else if (m_st[n] == 1) begin
        if (step) begin
          if (mk[n] + 1 < mdk[n]) begin
            mk[n] <= mk[n] + 1;
          end else if (mj[n] + 1 < mdj[n]) begin
            mk[n] <= 0;
            mj[n] <= mj[n] + 1;
          end else if (mi[n] + NC[n] < mdi[n]) begin
            mk[n] <= 0;
            mj[n] <= 0;
            mi[n] <= mi[n] + NC[n];
          end else begin
            m_st[n] <= 2;
          end
        end
      end else begin
        m_st[n] <= 0;
      end
    end
  end

  always @(negedge clock) begin
    if (cmp_en) begin
      for (int n = 0; n < 3; n++) begin
        chk($sformatf("valid%0d", n), int'(vl[n]), int'(m_st[n] == 1));
        chk($sformatf("busy%0d", n), int'(bz[n]), int'(m_st[n] != 0));
        chk($sformatf("done%0d", n), int'(dn[n]), int'(m_st[n] == 2));
        chk($sformatf("last_k%0d", n), int'(lk[n]),
            int'(m_st[n] == 1 && mk[n] == mdk[n] - 1));
        if (m_st[n] == 1) begin
          chk($sformatf("addr_a%0d", n), int'(a[n]),
              (mba[n] + mi[n] * mdk[n] + mk[n]) & 255);
          chk($sformatf("addr_b%0d", n), int'(b[n]),
              (mbb[n] + mk[n] * mdj[n] + mj[n]) & 255);
          chk($sformatf("addr_d%0d", n), int'(d[n]),
              (mbd[n] + mi[n] * mdj[n] + mj[n]) & 255);
        end
      end
    end
  end

  localparam int REF_A[8] = '{'h00, 'h01, 'h00, 'h01,
                              'h02, 'h03, 'h02, 'h03};
  localparam int REF_B[8] = '{'h10, 'h12, 'h11, 'h13,
                              'h10, 'h12, 'h11, 'h13};
  localparam int REF_D[8] = '{'h20, 'h20, 'h21, 'h21,
                              'h22, 'h22, 'h23, 'h23};
  localparam int WRAP_A[4] = '{'hFE, 'hFF, 'h00, 'h01};

  task automatic set_cfg(input int ni, input int nk, input int nj,
                         input int ba, input int bb, input int bd);
    dim_i  = 4'(ni);
    dim_k  = 4'(nk);
    dim_j  = 4'(nj);
    base_a = 8'(ba);
    base_b = 8'(bb);
    base_d = 8'(bd);
  endtask

  task automatic start_pulse();
    @(posedge clock);
    #1 start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
  endtask

  task automatic wait_idle();
    bit idle;
    idle = 1'b0;
    step = 1'b1;
    for (int c = 0; c < 400 && !idle; c++) begin
      @(negedge clock);
      idle = !bz[0] && !bz[1] && !bz[2];
    end
    chk("idle_timeout", int'(idle), 1);
  endtask

  task automatic run_ref();
    set_cfg(2, 2, 2, 'h00, 'h10, 'h20);
    step = 1'b1;
    start_pulse();
    for (int n = 0; n < 8; n++) begin
      @(negedge clock);
      chk($sformatf("ref_a[%0d]", n), int'(a[0]), REF_A[n]);
      chk($sformatf("ref_b[%0d]", n), int'(b[0]), REF_B[n]);
      chk($sformatf("ref_d[%0d]", n), int'(d[0]), REF_D[n]);
      chk($sformatf("ref_lk[%0d]", n), int'(lk[0]), n % 2);
    end
    @(negedge clock);
    chk("ref_done", int'(dn[0]), 1);
    chk("ref_valid_end", int'(vl[0]), 0);
    wait_idle();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int idx;
    bit s;

    repeat (2) @(posedge clock);
    #1 cmp_en = 1'b1;
    @(negedge clock);
    chk("rst_valid", int'(vl[0]), 0);
    chk("rst_busy", int'(bz[0]), 0);
    chk("rst_done", int'(dn[0]), 0);
    chk("rst_addr_a", int'(a[0]), 0);
    chk("rst_addr_d", int'(d[0]), 0);
    rst_n = 1'b1;

    run_ref();

    set_cfg(6, 3, 2, 'h00, 'h40, 'h80);
    step = 1'b1;
    start_pulse();
    @(negedge clock);
    chk("c1_first_a", int'(a[1]), 'h03);
    chk("c1_first_d", int'(d[1]), 'h82);
    repeat (6) @(negedge clock);
    chk("c1_row5_a", int'(a[1]), 'h0F);
    chk("c1_row5_d", int'(d[1]), 'h8A);
    wait_idle();

    set_cfg(1, 2, 2, 'h00, 'h10, 'h20);
    start_pulse();
    @(negedge clock);
    chk("empty_row_done", int'(dn[2]), 1);
    chk("empty_row_valid", int'(vl[2]), 0);
    @(negedge clock);
    chk("empty_row_done_clr", int'(dn[2]), 0);
    chk("empty_row_busy_clr", int'(bz[2]), 0);
    wait_idle();

    set_cfg(2, 0, 2, 'h00, 'h10, 'h20);
    start_pulse();
    @(negedge clock);
    chk("zero_k_done", int'(dn[0]), 1);
    chk("zero_k_valid", int'(vl[0]), 0);
    wait_idle();

    set_cfg(1, 4, 1, 'hFE, 'hFE, 'hFE);
    start_pulse();
    for (int n = 0; n < 4; n++) begin
      @(negedge clock);
      chk($sformatf("wrap_a[%0d]", n), int'(a[0]), WRAP_A[n]);
    end
    wait_idle();

    // random step, dims changed after start, ignored re-start
    set_cfg(2, 2, 2, 'h00, 'h10, 'h20);
    step = 1'b0;
    start_pulse();
    idx = 0;
    for (int it = 0; it < 300 && idx < 8; it++) begin
      @(negedge clock);
      s = 1'($urandom_range(0, 1));
      if (it == 1) begin
        dim_i = 4'd3;
        dim_k = 4'd3;
        dim_j = 4'd3;
      end
      start = (it == 4);
      if (vl[0] && s) begin
        chk($sformatf("rnd_a[%0d]", idx), int'(a[0]), REF_A[idx]);
        chk($sformatf("rnd_b[%0d]", idx), int'(b[0]), REF_B[idx]);
        chk($sformatf("rnd_d[%0d]", idx), int'(d[0]), REF_D[idx]);
        idx++;
      end
      step = s;
    end
    start = 1'b0;
    chk("rnd_count", idx, 8);
    @(negedge clock);
    chk("rnd_done", int'(dn[0]), 1);
    wait_idle();

    set_cfg(2, 2, 2, 'h00, 'h10, 'h20);
    step = 1'b1;
    start_pulse();
    repeat (3) @(negedge clock);
    @(posedge clock);
    #1 rst_n = 1'b0;
    @(posedge clock);
    #1 rst_n = 1'b1;
    @(negedge clock);
    chk("mid_rst_valid", int'(vl[0]), 0);
    chk("mid_rst_busy", int'(bz[0]), 0);
    chk("mid_rst_done", int'(dn[0]), 0);
    chk("mid_rst_a", int'(a[0]), 0);
    chk("mid_rst_b", int'(b[0]), 0);
    chk("mid_rst_d", int'(d[0]), 0);

    run_ref();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/matmul_addr_seq.md
Name: matmul_addr_seq

Overview:
- Parametrised successor to the per-core address path (step counters plus address registers) used by the matrix-multiplication cores.
- Generates row-major data-memory addresses for A (element i,k), B (element k,j) and D (element i,j) across a full i/j/k loop nest.
- Rows are interleaved across NUM_CORES cores, so each core instance processes rows i = CORE_ID, CORE_ID+NUM_CORES, ...
- Sits between the control unit (start/step handshake) and the data address register (DAR) mux.

Parameters:
ADDR_W, 8, data-memory address width
DIM_W, 4, width of each matrix dimension
NUM_CORES, 4, number of cores sharing the row space (>=1)
CORE_ID, 0, this core's first row index (0..NUM_CORES-1)

Ports:
clock  in  1  system clock, rising edge
rst_n  in  1  synchronous active-low reset
start  in  1  one-cycle request; sampled only in IDLE
dim_i  in  DIM_W  rows of A and D
dim_k  in  DIM_W  columns of A = rows of B
dim_j  in  DIM_W  columns of B and D
base_a  in  ADDR_W  base address of A
base_b  in  ADDR_W  base address of B
base_d  in  ADDR_W  base address of D
step  in  1  advance to the next (i,j,k); honoured only when valid=1
addr_a  out  ADDR_W  current A address
addr_b  out  ADDR_W  current B address
addr_d  out  ADDR_W  current D address
last_k  out  1  current k == dim_k-1 (the D write is due after this MAC)
valid  out  1  addresses are meaningful
busy  out  1  not IDLE
done  out  1  one-cycle pulse when the sequence completes

Behaviour:
- Reset: rst_n=0 at a clock edge forces IDLE and all outputs to 0. This applies mid-sequence too; no done pulse is produced on reset.
- FSM states: IDLE, RUN, FIN.
  - IDLE -> on start: latch dims and bases, then go to RUN. If CORE_ID >= dim_i, or any dim is 0, go to FIN instead.
  - RUN: valid=1, busy=1. Outputs are registered.
  - FIN: done=1 and busy=1 for exactly one cycle, then IDLE.
- Latency: the first addresses (i=CORE_ID, j=0, k=0) are valid in the cycle after start is sampled.
- Initial addresses:
  - addr_a = base_a + CORE_ID*dim_k
  - addr_b = base_b
  - addr_d = base_d + CORE_ID*dim_j
- Address tracking is incremental; no multiplier in the datapath. Initial products are formed by repeated add during a single-cycle precompute (CORE_ID is a constant), or by a constant multiply.
- Step rules (step=1 in RUN), evaluated in this order:
  - k < dim_k-1: k++, addr_a += 1, addr_b += dim_j.
  - else, j < dim_j-1: k=0, j++, addr_a = row_a, addr_b = base_b + j+1, addr_d += 1.
  - else, i+NUM_CORES < dim_i: k=j=0, i += NUM_CORES, row_a += NUM_CORES*dim_k, addr_a = new row_a, addr_b = base_b, addr_d += 1 + (NUM_CORES-1)*dim_j (the next assigned row start).
  - else: go to FIN, valid=0 in that cycle.
- step=0 holds all state and outputs.
- last_k is combinational from k and the latched dim_k, qualified by valid.
- start while busy is ignored; the latched config is unchanged.
- Arithmetic: all address sums are modulo 2^ADDR_W (silent wrap). i uses DIM_W+1 bits so i+NUM_CORES cannot overflow.
- Dimension inputs may change freely after start; only the latched copies are used.

Decomposition:
- Shared package matmul_pkg holds:
  - FSM state typedef (IDLE/RUN/FIN)
  - ADDR_W and DIM_W defaults
  - a function for the row-stride product
- One natural sub-module, mm_loop_counter: a reusable wrap counter with inc, clear, limit, and a wrap flag. It is instantiated three times (k, j, i with step NUM_CORES).

Test Plan:
- Config 2x2x2 (i,k,j), NUM_CORES=1, bases A=0x00, B=0x10, D=0x20, step held high.
  - Expect 8 tuples (a,b,d): (00,10,20) (01,12,20) (00,11,21) (01,13,21) (02,10,22) (03,12,22) (02,11,23) (03,13,23).
  - last_k high on every 2nd tuple; done one cycle after the 8th step.
- NUM_CORES=4, CORE_ID=1, dims i=6, k=3, j=2.
  - Expect rows 1 and 5 only.
  - First addr_a=0x03; after 6 steps addr_a=0x0F, addr_d=base_d+10.
- dim_i=1 with CORE_ID=2, or dim_k=0.
  - Expect no valid cycle; done pulses on the 2nd cycle after start.
- Bases 0xFE, k=4 -> addr_a wraps FE, FF, 00, 01.
- step toggled randomly, and start re-asserted mid-run.
  - Outputs hold while step=0; the re-start is ignored; the sequence matches the step-held-high reference.
- rst_n=0 for one cycle mid-RUN.
  - Next cycle valid=busy=done=0 and all addresses 0.
  - A fresh start then reproduces the first test's sequence.
